// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory-port arbiter.
//   state_t : arbiter FSM state (IDLE / BUSY)
//   REQ_IF  : port-owner encoding for instruction fetch (matches sel = 0)
//   REQ_D   : port-owner encoding for data load/store   (matches sel = 1)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mux2by1.sv
// -----------------------------------------------------------------------------
// mux2by1
// Plain two-input multiplexer.
//   in1_i : selected when sel_i = 0
//   in2_i : selected when sel_i = 1
//   sel_i : select
//   out_o : selected value
// -----------------------------------------------------------------------------
module mux2by1 #(
    parameter int N = 32
) (
    input  logic [N-1:0] in1_i,
    input  logic [N-1:0] in2_i,
    input  logic         sel_i,
    output logic [N-1:0] out_o
);

    assign out_o = sel_i ? in2_i : in1_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates the single shared memory port between instruction fetch and the
// load/store unit. One requester is granted at a time, its address/data are
// latched, and the port is held for LAT cycles before a one-cycle done pulse.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   if_req_i, if_addr_i   : fetch request (held until if_done_o) and address
//   d_req_i, d_we_i       : data request (held until d_done_o), 1 = store
//   d_addr_i, d_wdata_i   : data address and store data
//   mem_rdata_i           : memory read data, valid in the last BUSY cycle
//   mem_en_o, mem_we_o    : memory enable / write enable
//   mem_addr_o, mem_wdata_o : latched address / store data
//   sel_o                 : port owner, 0 = fetch, 1 = data
//   if_gnt_o, d_gnt_o     : requester currently owns the port
//   if_done_o, d_done_o   : one-cycle completion pulses
//   rdata_o               : registered read data (updated on loads only)
// -----------------------------------------------------------------------------
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int N   = 32,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req_i,
    input  logic [N-1:0] if_addr_i,
    input  logic         d_req_i,
    input  logic         d_we_i,
    input  logic [N-1:0] d_addr_i,
    input  logic [N-1:0] d_wdata_i,
    input  logic [N-1:0] mem_rdata_i,
    output logic         mem_en_o,
    output logic         mem_we_o,
    output logic [N-1:0] mem_addr_o,
    output logic [N-1:0] mem_wdata_o,
    output logic         sel_o,
    output logic         if_gnt_o,
    output logic         d_gnt_o,
    output logic         if_done_o,
    output logic         d_done_o,
    output logic [N-1:0] rdata_o
);

    localparam int CNT_W = $clog2(LAT) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [N-1:0]       mem_addr_q, mem_addr_d;
    logic [N-1:0]       mem_wdata_q, mem_wdata_d;
    logic               sel_q, sel_d;
    logic               if_gnt_q, if_gnt_d;
    logic               d_gnt_q, d_gnt_d;
    logic               if_done_q, if_done_d;
    logic               d_done_q, d_done_d;
    logic [N-1:0]       rdata_q, rdata_d;
    logic               last_gnt_q, last_gnt_d;

    logic               win_sel;
    logic [N-1:0]       win_addr;

    // A lone requester always wins; on a tie the one not served last wins.
    assign win_sel = (if_req_i && d_req_i) ? ~last_gnt_q : d_req_i;

    mux2by1 #(.N(N)) u_addr_mux (
        .in1_i (if_addr_i),
        .in2_i (d_addr_i),
        .sel_i (win_sel),
        .out_o (win_addr)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        sel_d       = sel_q;
        if_gnt_d    = if_gnt_q;
        d_gnt_d     = d_gnt_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        rdata_d     = rdata_q;
        last_gnt_d  = last_gnt_q;

        case (state_q)
            IDLE: begin
                // The done cycle is also IDLE, so a waiting requester is
                // granted on the edge that ends it with no extra bubble.
                if (if_req_i || d_req_i) begin
                    state_d     = BUSY;
                    cnt_d       = CNT_W'(LAT - 1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we_i & (win_sel == REQ_D);
                    mem_addr_d  = win_addr;
                    mem_wdata_d = d_wdata_i;
                    sel_d       = win_sel;
                    if_gnt_d    = (win_sel == REQ_IF);
                    d_gnt_d     = (win_sel == REQ_D);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    if_done_d  = (sel_q == REQ_IF);
                    d_done_d   = (sel_q == REQ_D);
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    if_gnt_d   = 1'b0;
                    d_gnt_d    = 1'b0;
                    last_gnt_d = sel_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            sel_q       <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            rdata_q     <= '0;
            // Data counts as served last so fetch wins the first tie.
            last_gnt_q  <= REQ_D;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            sel_q       <= sel_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            rdata_q     <= rdata_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign sel_o       = sel_q;
    assign if_gnt_o    = if_gnt_q;
    assign d_gnt_o     = d_gnt_q;
    assign if_done_o   = if_done_q;
    assign d_done_o    = d_done_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by randomized request traffic, all compared
// cycle by cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int N   = 32;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req, d_req, d_we;
    logic [N-1:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic         mem_en, mem_we, sel, if_gnt, d_gnt, if_done, d_done;
    logic [N-1:0] mem_addr, mem_wdata, rdata;

    mem_port_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .sel_o       (sel),
        .if_gnt_o    (if_gnt),
        .d_gnt_o     (d_gnt),
        .if_done_o   (if_done),
        .d_done_o    (d_done),
        .rdata_o     (rdata)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int txn_cnt    = 0;

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int           m_left;     // BUSY cycles still to run, 0 = port free
    logic         m_owner;    // 0 = fetch, 1 = data
    logic         m_last;
    logic         m_we;
    logic [N-1:0] m_addr, m_wdata, m_rdata;
    logic         m_done_if, m_done_d;

    function automatic void model_reset();
        m_left    = 0;
        m_owner   = 1'b0;
        m_last    = 1'b1;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_rdata   = '0;
        m_done_if = 1'b0;
        m_done_d  = 1'b0;
    endfunction

    // One rising edge with the inputs currently applied.
    function automatic void model_edge();
        m_done_if = 1'b0;
        m_done_d  = 1'b0;
        if (m_left == 1) begin
            if (!m_we) m_rdata = mem_rdata;
            if (m_owner) m_done_d = 1'b1;
            else         m_done_if = 1'b1;
            m_last = m_owner;
            m_left = 0;
            txn_cnt++;
            $display("txn %0d: %s %s addr=%h wdata=%h rdata=%h", txn_cnt,
                     m_owner ? "data" : "fetch", m_we ? "store" : "load",
                     m_addr, m_wdata, m_rdata);
        end else if (m_left > 1) begin
            m_left--;
        end else if (if_req || d_req) begin
            m_owner = (if_req && d_req) ? !m_last : d_req;
            m_addr  = m_owner ? d_addr : if_addr;
            m_we    = m_owner && d_we;
            m_wdata = d_wdata;
            m_left  = LAT;
        end
    endfunction

    task automatic check_all();
        logic busy;
        busy = (m_left > 0);
        check_val("mem_en",    N'(mem_en),  N'(busy));
        check_val("mem_we",    N'(mem_we),  N'(busy && m_we));
        check_val("mem_addr",  mem_addr,    m_addr);
        check_val("mem_wdata", mem_wdata,   m_wdata);
        check_val("sel",       N'(sel),     N'(m_owner));
        check_val("if_gnt",    N'(if_gnt),  N'(busy && !m_owner));
        check_val("d_gnt",     N'(d_gnt),   N'(busy && m_owner));
        check_val("if_done",   N'(if_done), N'(m_done_if));
        check_val("d_done",    N'(d_done),  N'(m_done_d));
        check_val("rdata",     rdata,       m_rdata);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int           gnt_order[$];
    logic         prev_if_gnt, prev_d_gnt;
    int           done_gap, last_done_t;
    logic         if_pend, d_pend;

    initial begin
        rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        model_reset();

        // Reset then idle for 10 cycles.
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check_val("idle_sel", N'(sel), '0);

        // Fetch only.
        mem_rdata = 32'hDEADBEEF;
        if_req = 1; if_addr = 32'h100;
        step();
        check_val("fetch_gnt", N'(if_gnt), N'(1'b1));
        check_val("fetch_addr", mem_addr, 32'h100);
        step();
        step();
        check_val("fetch_done", N'(if_done), N'(1'b1));
        check_val("fetch_rdata", rdata, 32'hDEADBEEF);
        if_req = 0;
        step();

        // Store: rdata must stay at the fetched value.
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
        mem_rdata = 32'hCAFEF00D;
        step();
        check_val("store_sel", N'(sel), N'(1'b1));
        check_val("store_we", N'(mem_we), N'(1'b1));
        check_val("store_wdata", mem_wdata, 32'h12345678);
        step();
        step();
        check_val("store_done", N'(d_done), N'(1'b1));
        check_val("store_rdata", rdata, 32'hDEADBEEF);
        d_req = 0; d_we = 0;
        step();

        // Data request arriving while fetch is busy.
        if_req = 1; if_addr = 32'h300; mem_rdata = 32'h0000_1111;
        step();
        d_req = 1; d_addr = 32'h400;
        step();
        step();
        check_val("late_if_done", N'(if_done), N'(1'b1));
        if_req = 0;
        step();
        check_val("late_d_gnt", N'(d_gnt), N'(1'b1));
        check_val("late_d_addr", mem_addr, 32'h400);
        step();
        step();
        check_val("late_d_done", N'(d_done), N'(1'b1));
        d_req = 0;
        step();

        // Both requesting continuously from reset: F, D, F, D, done every 3.
        do_reset();
        if_req = 1; d_req = 1; if_addr = 32'hA0; d_addr = 32'hB0;
        prev_if_gnt = 0; prev_d_gnt = 0; last_done_t = -1;
        for (int i = 0; i < 12; i++) begin
            mem_rdata = $urandom;
            step();
            if (if_gnt && !prev_if_gnt) gnt_order.push_back(0);
            if (d_gnt && !prev_d_gnt)   gnt_order.push_back(1);
            prev_if_gnt = if_gnt; prev_d_gnt = d_gnt;
            if (if_done || d_done) begin
                if (last_done_t >= 0) check_val("done_spacing", N'(i - last_done_t), N'(LAT + 1));
                last_done_t = i;
            end
        end
        check_val("gnt_count", N'(gnt_order.size()), N'(4));
        for (int k = 0; k < gnt_order.size(); k++)
            check_val("gnt_order", N'(gnt_order[k]), N'(k % 2));

        // Reset in the second BUSY cycle.
        do_reset();
        if_req = 1; d_req = 1; mem_rdata = 32'h5555AAAA;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_mem_en", N'(mem_en), '0);
        check_val("rst_if_gnt", N'(if_gnt), '0);
        check_val("rst_mem_addr", mem_addr, '0);
        step();
        check_val("rst_no_done", N'(if_done | d_done), '0);
        rst = 1'b0;
        step();
        check_val("rst_tie_fetch", N'(if_gnt), N'(1'b1));
        if_req = 0; d_req = 0;
        for (int i = 0; i < LAT + 1; i++) step();

        // Randomized traffic; requests held until their done, occasionally
        // dropped early while granted.
        if_pend = 0; d_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!if_pend && ($urandom % 3 == 0)) begin
                if_pend = 1; if_addr = $urandom;
            end
            if (!d_pend && ($urandom % 3 == 0)) begin
                d_pend = 1; d_addr = $urandom; d_wdata = $urandom; d_we = $urandom % 2;
            end
            if (if_gnt && ($urandom % 16 == 0)) if_pend = 0;
            if (d_gnt && ($urandom % 16 == 0)) d_pend = 0;
            if_req = if_pend; d_req = d_pend;
            mem_rdata = $urandom;
            step();
            if (if_done) if_pend = 0;
            if (d_done)  d_pend = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
